mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory (instructions at the top, data at the bottom) between the instruction-fetch requester and the data-access (LW/SW) requester.
- Arbitrates between the two, maps data addresses to the bottom of memory, and drives the single memory port.
- Returns registered read data with a one-cycle valid pulse per completed access.
- Sits between the CPU stages and the memory array; replaces the dual read ports with a shared port.

Parameters:
- wordNumber, 64, number of memory words.
- n, 32, word width in bits.
- m, 6, address width in bits.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- instrReq  in  1  fetch request; hold high until instrValid.
- instrAddr  in  m  fetch word address (top-relative).
- instrRdata  out  n  registered fetched word.
- instrValid  out  1  one-cycle pulse: instrRdata valid.
- dataReq  in  1  data request; hold high until dataValid.
- dataWe  in  1  1 = store, 0 = load; sampled with dataReq.
- dataAddr  in  m  data word address (bottom-relative).
- dataWdata  in  n  store data.
- dataRdata  out  n  registered load data.
- dataValid  out  1  one-cycle pulse: load data valid or store done.
- memAddr  out  m  physical address to memory array.
- memWdata  out  n  write data to memory array.
- memWe  out  1  memory write enable, taken at Clk rising edge.
- memRdata  in  n  combinational read data from memory array.

Behaviour:
- Clock and reset: one clock (Clk); reset (Reset) is synchronous and active-high. All state updates on the Clk rising edge.
- Reset values:
  - state = IDLE, lastGrant = INSTR.
  - instrValid = dataValid = 0, instrRdata = dataRdata = 0.
  - Latched address, write data and write flag = 0.
  - memWe = 0, including during the reset cycle itself.
- States:
  - IDLE: no access in flight.
  - GNT_I: serving a fetch.
  - GNT_D: serving a data access.
- Arbitration, at each edge in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the requester other than lastGrant (round-robin). After reset, data wins the first tie.
- On a grant:
  - Latch the address; for data also latch dataWe and dataWdata.
  - Set lastGrant and enter the GNT state.
- Address mapping:
  - Fetch: memAddr = latched instrAddr.
  - Data: memAddr = wordNumber-1-latched dataAddr, truncated to m bits (modulo 2^m).
  - In IDLE, memAddr = 0 and memWdata = 0.
- In GNT_I / GNT_D (exactly one cycle):
  - memWe = (GNT_D & latched we & ~Reset).
  - On the closing edge:
    - GNT_I: instrRdata <= memRdata, instrValid <= 1.
    - GNT_D load: dataRdata <= memRdata, dataValid <= 1.
    - GNT_D store: dataRdata holds its value, dataValid <= 1.
- Valid pulses last exactly one cycle and are cleared on the following edge.
- Latency:
  - Request high at edge k gives the grant cycle k+1 and the valid pulse in cycle k+2.
  - Both requesters continuously requesting: one access completes per cycle, alternating I/D.
- Back-to-back:
  - From a GNT state, arbitration runs in the same cycle but excludes the requester currently being served (its request is still high).
  - If the other requester is pending, go directly to its GNT state; otherwise go to IDLE.
- New requests:
  - req high in the cycle its valid is high counts as a new request; its address and data are sampled at that edge.
  - A requester must not change address, we or wdata while waiting for its valid.
- Request dropped before valid: not allowed. The arbiter completes the latched access anyway and still pulses valid.
- Reset mid-access:
  - Access aborted; no memory write in the reset cycle.
  - No valid pulse; return to IDLE.
- Starvation bound: each requester waits at most 2 cycles from request to grant.

Test Plan:
- Reset, then instrReq=1, instrAddr=3 held, memory[3]=0x2002000A → grant next cycle, memAddr=3, instrValid=1 with instrRdata=0x2002000A two cycles after the request edge.
- dataReq=1, dataWe=0, dataAddr=0, memory[63]=16 → memAddr=63, dataValid pulse with dataRdata=16; dataAddr=1 maps to memAddr=62.
- Store dataAddr=0, dataWdata=0x55 → exactly one cycle with memWe=1, memAddr=63, memWdata=0x55; dataValid pulses; a subsequent load of dataAddr=0 returns 0x55.
- instrReq and dataReq both raised in the same cycle right after reset, both held → grants D, I, D, I on successive cycles; valids alternate every cycle, starting with data.
- Reset asserted during a GNT_D store → memWe stays 0, no dataValid, memory word unchanged, state back to IDLE.
- Data address wrap: dataAddr=63 → memAddr=0; instrAddr=63 → memAddr=63.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one unified memory port between
// instruction fetch (top-relative) and data load/store (bottom-relative).
module mem_port_arbiter #(
    parameter int wordNumber = 64,
    parameter int n = 32,
    parameter int m = 6
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         instrReq,
    input  logic [m-1:0] instrAddr,
    output logic [n-1:0] instrRdata,
    output logic         instrValid,
    input  logic         dataReq,
    input  logic         dataWe,
    input  logic [m-1:0] dataAddr,
    input  logic [n-1:0] dataWdata,
    output logic [n-1:0] dataRdata,
    output logic         dataValid,
    output logic [m-1:0] memAddr,
    output logic [n-1:0] memWdata,
    output logic         memWe,
    input  logic [n-1:0] memRdata
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    localparam logic [m-1:0] TOP = m'(wordNumber - 1);
    state_t state, nxt;
    logic last_d;
    logic [m-1:0] i_addr, d_addr;
    logic d_we;
    logic [n-1:0] d_wdata;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != IDLE) last_d <= (nxt == GNT_D);
        end
    end
    // the requester being served is excluded, so a GNT state never repeats itself
    always_comb begin
        nxt = state == GNT_I ? (dataReq ? GNT_D : IDLE) :
              state == GNT_D ? (instrReq ? GNT_I : IDLE) :
              (instrReq & dataReq) ? (last_d ? GNT_I : GNT_D) :
              dataReq ? GNT_D : instrReq ? GNT_I : IDLE;
    end
    always_comb begin
        memAddr  = state == GNT_I ? i_addr : state == GNT_D ? TOP - d_addr : '0;
        memWdata = state == GNT_D ? d_wdata : '0;
        memWe    = (state == GNT_D) & d_we & ~Reset;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            i_addr     <= '0;
            d_addr     <= '0;
            d_we       <= 1'b0;
            d_wdata    <= '0;
            instrValid <= 1'b0;
            dataValid  <= 1'b0;
            instrRdata <= '0;
            dataRdata  <= '0;
        end else begin
            if (nxt == GNT_I) i_addr <= instrAddr;
            if (nxt == GNT_D) begin
                d_addr  <= dataAddr;
                d_we    <= dataWe;
                d_wdata <= dataWdata;
            end
            instrValid <= state == GNT_I;
            dataValid  <= state == GNT_D;
            if (state == GNT_I) instrRdata <= memRdata;
            if (state == GNT_D && !d_we) dataRdata <= memRdata;
        end
    end
endmodule
